// File: rtl/nav_pkg.sv
// Shared types and default tuning constants for the navigation command controller.
package nav_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TURN,
        RAMP_UP,
        RAMP_DN
    } nav_state_t;

    localparam logic [10:0]  DEF_MAX_FRWRD  = 11'h2A0;
    localparam logic [10:0]  DEF_MIN_FRWRD  = 11'h0D0;
    localparam logic [5:0]   DEF_FRWRD_INC  = 6'h02;
    localparam int unsigned  DEF_SETTLE_CYC = 2;

endpackage

// File: rtl/nav_cmd_ctrl_if.sv
// Command bus between the maze solver (master) and the navigation controller (slave).
interface nav_cmd_if;

    logic        strt_hdng;
    logic        strt_mv;
    logic        stp_lft;
    logic        stp_rght;
    logic [11:0] cmd_hdng;
    logic        mv_cmplt;

    modport master (
        output strt_hdng, strt_mv, stp_lft, stp_rght, cmd_hdng,
        input  mv_cmplt
    );

    modport slave (
        input  strt_hdng, strt_mv, stp_lft, stp_rght, cmd_hdng,
        output mv_cmplt
    );

endinterface

// File: rtl/nav_spd_ramp.sv
// Forward speed register: clear, load, ramp up with ceiling, ramp down with floor at zero.
module nav_spd_ramp
    import nav_pkg::*;
#(
    parameter logic [10:0] MAX_FRWRD = DEF_MAX_FRWRD,
    parameter logic [10:0] MIN_FRWRD = DEF_MIN_FRWRD,
    parameter logic [5:0]  FRWRD_INC = DEF_FRWRD_INC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        load,
    input  logic        inc,
    input  logic        dec,
    input  logic [11:0] dec_amt,
    output logic [10:0] spd,
    output logic        last_step
);

    localparam logic [11:0] MAX_EXT = {1'b0, MAX_FRWRD};

    logic [11:0] spd_ext;
    logic [11:0] sum;
    logic [11:0] nxt;

    // Next speed at 12 bits; a decrement that would reach or pass zero lands on zero.
    always_comb begin
        spd_ext   = {1'b0, spd};
        sum       = spd_ext + {6'd0, FRWRD_INC};
        last_step = (spd_ext <= dec_amt);
        nxt       = spd_ext;
        if (clr)
            nxt = '0;
        else if (load)
            nxt = {1'b0, MIN_FRWRD};
        else if (inc)
            nxt = (sum > MAX_EXT) ? MAX_EXT : sum;
        else if (dec)
            nxt = last_step ? '0 : (spd_ext - dec_amt);
    end

    // Speed register, saturated back into 11 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            spd <= '0;
        else
            spd <= nxt[11] ? MAX_FRWRD : nxt[10:0];
    end

endmodule

// File: rtl/nav_cmd_ctrl.sv
// Turn/move command sequencer feeding the heading/speed PID loop.
module nav_cmd_ctrl
    import nav_pkg::*;
#(
    parameter logic [10:0] MAX_FRWRD  = DEF_MAX_FRWRD,
    parameter logic [10:0] MIN_FRWRD  = DEF_MIN_FRWRD,
    parameter logic [5:0]  FRWRD_INC  = DEF_FRWRD_INC,
    parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic        clk,
    input  logic        rst_n,
    nav_cmd_if.slave    cmd,
    input  logic        at_hdng,
    input  logic        hdng_vld,
    input  logic        lft_opn,
    input  logic        rght_opn,
    input  logic        frwrd_opn,
    output logic [11:0] dsrd_hdng,
    output logic        moving,
    output logic [10:0] frwrd_spd,
    output logic        en_fusion
);

    localparam logic [3:0]  SETTLE_LD = 4'(SETTLE_CYC);
    localparam logic [11:0] NORM_DEC  = {5'd0, FRWRD_INC, 1'b0};
    localparam logic [11:0] FAST_DEC  = {4'd0, FRWRD_INC, 2'b0};

    nav_state_t  state;
    logic [3:0]  settle_cnt;
    logic        lft_opn_q;
    logic        rght_opn_q;
    logic        fast_dec;
    logic        mv_cmplt_r;

    logic        stop_req;
    logic        fast_eff;
    logic [11:0] dec_amt;
    logic        spd_clr;
    logic        spd_load;
    logic        spd_inc;
    logic        spd_dec;
    logic        spd_last;

    // Opening edge detect, decel selection and speed-register controls.
    always_comb begin
        stop_req = (cmd.stp_lft  & lft_opn  & ~lft_opn_q) |
                   (cmd.stp_rght & rght_opn & ~rght_opn_q);
        fast_eff = fast_dec | ~frwrd_opn;
        dec_amt  = fast_eff ? FAST_DEC : NORM_DEC;
        spd_clr  = (state == TURN);
        spd_load = (state == IDLE) & ~cmd.strt_hdng & cmd.strt_mv & frwrd_opn;
        spd_inc  = (state == RAMP_UP) & hdng_vld;
        spd_dec  = (state == RAMP_DN) & hdng_vld;
    end

    // Command FSM with registered heading, moving and completion outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dsrd_hdng  <= '0;
            moving     <= 1'b0;
            mv_cmplt_r <= 1'b0;
            settle_cnt <= '0;
            lft_opn_q  <= 1'b0;
            rght_opn_q <= 1'b0;
            fast_dec   <= 1'b0;
        end else begin
            lft_opn_q  <= lft_opn;
            rght_opn_q <= rght_opn;
            mv_cmplt_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd.strt_hdng) begin
                        dsrd_hdng  <= cmd.cmd_hdng;
                        settle_cnt <= SETTLE_LD;
                        state      <= TURN;
                        moving     <= 1'b1;
                    end else if (cmd.strt_mv) begin
                        if (frwrd_opn) begin
                            state  <= RAMP_UP;
                            moving <= 1'b1;
                        end else begin
                            mv_cmplt_r <= 1'b1;
                        end
                    end
                end
                TURN: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end else if (at_hdng) begin
                        mv_cmplt_r <= 1'b1;
                        state      <= IDLE;
                        moving     <= 1'b0;
                    end
                end
                RAMP_UP: begin
                    if (!frwrd_opn) begin
                        fast_dec <= 1'b1;
                        state    <= RAMP_DN;
                    end else if (stop_req) begin
                        fast_dec <= 1'b0;
                        state    <= RAMP_DN;
                    end
                end
                RAMP_DN: begin
                    fast_dec <= fast_eff;
                    if (hdng_vld && spd_last) begin
                        mv_cmplt_r <= 1'b1;
                        state      <= IDLE;
                        moving     <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    moving <= 1'b0;
                end
            endcase
        end
    end

    assign cmd.mv_cmplt = mv_cmplt_r;
    assign en_fusion    = (frwrd_spd > (MAX_FRWRD >> 1));

    nav_spd_ramp #(
        .MAX_FRWRD (MAX_FRWRD),
        .MIN_FRWRD (MIN_FRWRD),
        .FRWRD_INC (FRWRD_INC)
    ) u_spd_ramp (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (spd_clr),
        .load      (spd_load),
        .inc       (spd_inc),
        .dec       (spd_dec),
        .dec_amt   (dec_amt),
        .spd       (frwrd_spd),
        .last_step (spd_last)
    );

endmodule

// File: tb/tb_nav_cmd_ctrl.sv
// Self-checking bench for nav_cmd_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_nav_cmd_ctrl;

    logic        clk;
    logic        rst_n;
    logic        at_hdng;
    logic        hdng_vld;
    logic        lft_opn;
    logic        rght_opn;
    logic        frwrd_opn;
    logic [11:0] dsrd_hdng;
    logic        moving;
    logic [10:0] frwrd_spd;
    logic        en_fusion;

    nav_cmd_if cif ();

    nav_cmd_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cif),
        .at_hdng   (at_hdng),
        .hdng_vld  (hdng_vld),
        .lft_opn   (lft_opn),
        .rght_opn  (rght_opn),
        .frwrd_opn (frwrd_opn),
        .dsrd_hdng (dsrd_hdng),
        .moving    (moving),
        .frwrd_spd (frwrd_spd),
        .en_fusion (en_fusion)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc      = 0;

    // Behavioural model: what the controller is busy with, and the speed as a plain integer.
    bit          m_turn, m_move, m_decel, m_fast, m_cmplt, m_lq, m_rq;
    int          m_settle;
    int          m_spd;
    logic [11:0] m_hdng;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_turn = 0; m_move = 0; m_decel = 0; m_fast = 0; m_cmplt = 0;
        m_lq = 0; m_rq = 0; m_settle = 0; m_spd = 0; m_hdng = '0;
    endtask

    // One clock of the command rules, using the inputs present at the edge.
    task automatic model_step();
        int step;
        m_cmplt = 0;
        if (m_turn) begin
            m_spd = 0;
            if (m_settle > 0)
                m_settle--;
            else if (at_hdng) begin
                m_turn = 0;
                m_cmplt = 1;
            end
        end else if (m_move) begin
            if (!m_decel) begin
                if (hdng_vld)
                    m_spd = (m_spd + 2 > 'h2A0) ? 'h2A0 : m_spd + 2;
                if (!frwrd_opn) begin
                    m_decel = 1; m_fast = 1;
                end else if ((cif.stp_lft && lft_opn && !m_lq) || (cif.stp_rght && rght_opn && !m_rq)) begin
                    m_decel = 1; m_fast = 0;
                end
            end else begin
                if (!frwrd_opn)
                    m_fast = 1;
                if (hdng_vld) begin
                    step = m_fast ? 8 : 4;
                    if (m_spd <= step) begin
                        m_spd = 0; m_move = 0; m_cmplt = 1;
                    end else begin
                        m_spd = m_spd - step;
                    end
                end
            end
        end else begin
            if (cif.strt_hdng) begin
                m_hdng = cif.cmd_hdng; m_settle = 2; m_turn = 1; m_spd = 0;
            end else if (cif.strt_mv) begin
                if (frwrd_opn) begin
                    m_spd = 'hD0; m_move = 1; m_decel = 0;
                end else begin
                    m_cmplt = 1;
                end
            end
        end
        m_lq = lft_opn;
        m_rq = rght_opn;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check_eq("dsrd_hdng", 32'(dsrd_hdng), 32'(m_hdng));
        check_eq("moving", 32'(moving), 32'(m_turn | m_move));
        check_eq("frwrd_spd", 32'(frwrd_spd), 32'(m_spd));
        check_eq("en_fusion", 32'(en_fusion), 32'(m_spd > 'h150));
        check_eq("mv_cmplt", 32'(cif.mv_cmplt), 32'(m_cmplt));
        cif.strt_hdng = 1'b0;
        cif.strt_mv   = 1'b0;
    endtask

    // Tick with a gyro sample every fourth cycle.
    task automatic dtick();
        hdng_vld = (cyc % 4 == 0);
        tick();
    endtask

    task automatic run_until_idle(input int max_cyc);
        for (int i = 0; i < max_cyc && (m_turn || m_move); i++)
            dtick();
        check_eq("wait_idle", 32'(m_turn | m_move), 32'd0);
    endtask

    task automatic run_until_spd(input int target, input int max_cyc);
        for (int i = 0; i < max_cyc && m_spd != target; i++)
            dtick();
        check_eq("wait_spd", 32'(m_spd), 32'(target));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_hdng"}, 32'(dsrd_hdng), 32'd0);
        check_eq({tag, "_moving"}, 32'(moving), 32'd0);
        check_eq({tag, "_spd"}, 32'(frwrd_spd), 32'd0);
        check_eq({tag, "_fusion"}, 32'(en_fusion), 32'd0);
        check_eq({tag, "_cmplt"}, 32'(cif.mv_cmplt), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        cif.strt_hdng = 0; cif.strt_mv = 0; cif.stp_lft = 0; cif.stp_rght = 0; cif.cmd_hdng = '0;
        at_hdng = 0; hdng_vld = 0; lft_opn = 0; rght_opn = 0; frwrd_opn = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Turn: at_hdng during settle ignored, honoured afterwards.
        cif.cmd_hdng = 12'h3FF;
        cif.strt_hdng = 1;
        dtick();
        check_eq("t1_hdng", 32'(dsrd_hdng), 32'h3FF);
        check_eq("t1_moving", 32'(moving), 32'd1);
        at_hdng = 1; dtick();
        at_hdng = 0; dtick();
        dtick(); dtick();
        at_hdng = 1; dtick();
        check_eq("t1_cmplt", 32'(cif.mv_cmplt), 32'd1);
        at_hdng = 0; dtick();

        // Ramp up to the ceiling and hold.
        frwrd_opn = 1; cif.strt_mv = 1;
        dtick();
        check_eq("t2_min", 32'(frwrd_spd), 32'h0D0);
        run_until_spd('h2A0, 2000);
        repeat (20) dtick();
        check_eq("t2_ceiling", 32'(frwrd_spd), 32'h2A0);

        // Normal stop at a left opening; held opening must not re-trigger.
        cif.stp_lft = 1; lft_opn = 1;
        run_until_idle(2000);
        cif.strt_mv = 1;
        dtick();
        run_until_spd('h2A0, 2000);
        repeat (16) dtick();
        check_eq("t3_no_retrig", 32'(moving), 32'd1);

        // Fast stop from the ceiling, then a fast stop from 0x0D6 reaching 0x006 -> 0.
        frwrd_opn = 0;
        run_until_idle(2000);
        cif.stp_lft = 0; lft_opn = 0;
        cif.strt_mv = 1; dtick();
        check_eq("t4_blocked_cmplt", 32'(cif.mv_cmplt), 32'd1);
        check_eq("t4_blocked_moving", 32'(moving), 32'd0);
        frwrd_opn = 1; cif.strt_mv = 1; dtick();
        run_until_spd('hD6, 100);
        hdng_vld = 0; frwrd_opn = 0; tick();
        run_until_spd('h006, 1000);
        run_until_idle(50);
        check_eq("t4_floor", 32'(frwrd_spd), 32'd0);

        // Normal decel upgraded to fast when the way ahead closes.
        frwrd_opn = 1; cif.stp_rght = 1; rght_opn = 0; cif.strt_mv = 1;
        dtick();
        run_until_spd('h120, 1000);
        rght_opn = 1;
        repeat (12) dtick();
        frwrd_opn = 0;
        run_until_idle(1000);
        rght_opn = 0; cif.stp_rght = 0; frwrd_opn = 1;
        dtick();

        // Simultaneous starts, ignored start during turn, reset mid-move.
        cif.cmd_hdng = 12'h123; cif.strt_hdng = 1; cif.strt_mv = 1;
        dtick();
        check_eq("t6_turn_only", 32'(frwrd_spd), 32'd0);
        cif.strt_mv = 1; dtick();
        at_hdng = 1;
        run_until_idle(20);
        at_hdng = 0;
        cif.strt_mv = 1; dtick();
        run_until_spd('h110, 500);
        rst_n = 1'b0;
        #2;
        check_all_zero("mid_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic.
        for (int i = 0; i < 6000; i++) begin
            cif.strt_hdng = ($urandom_range(0, 99) == 0);
            cif.strt_mv   = ($urandom_range(0, 99) < 3);
            cif.cmd_hdng  = 12'($urandom);
            if ($urandom_range(0, 49) == 0) cif.stp_lft  = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 49) == 0) cif.stp_rght = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 29) == 0) lft_opn  = ~lft_opn;
            if ($urandom_range(0, 29) == 0) rght_opn = ~rght_opn;
            if (frwrd_opn) begin
                if ($urandom_range(0, 399) == 0) frwrd_opn = 0;
            end else if ($urandom_range(0, 19) == 0) begin
                frwrd_opn = 1;
            end
            at_hdng  = ($urandom_range(0, 3) == 0);
            hdng_vld = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
